iic_slave_reg16: RTL and testbench

- I2C target (responder) holding a 16-bit-addressed, 8-bit-data register file.
- It is the other end of the sensor configuration master. The master sends frames {dev 8'h90, reg addr 16 bits, data 8 bits}.
- Used in iic_sim as a synthesizable sensor stand-in. It captures config writes and serves read-backs, so the bench can check the LUT-driven init sequence.
- SCL/SDA are oversampled on the system clock; SDA is driven open-drain.

---
 rtl/iic_slave_pkg.sv | 31 +++
 rtl/iic_slave_regfile.sv | 76 +++++++
 rtl/iic_slave_reg16.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_iic_slave_reg16.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_slave_pkg.sv
// Shared types and constants for the 16-bit-addressed I2C register target.
package iic_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DEV     = 4'd1,
    ST_DEV_ACK = 4'd2,
    ST_RA_HI   = 4'd3,
    ST_ACK_HI  = 4'd4,
    ST_RA_LO   = 4'd5,
    ST_ACK_LO  = 4'd6,
    ST_WDAT    = 4'd7,
    ST_ACK_W   = 4'd8,
    ST_RDAT    = 4'd9,
    ST_MACK    = 4'd10
  } state_t;

  localparam int         BCNT_W     = 3;
  localparam int         RW_BIT     = 0;
  localparam logic       RW_WRITE   = 1'b0;
  localparam logic       RW_READ    = 1'b1;
  localparam logic [7:0] RD_OOR_VAL = 8'hFF;

  // True when the pointer falls inside the implemented register file.
  function automatic logic addr_in_range(input logic [15:0] ptr, input int unsigned aw);
    logic [15:0] upper_s;
    upper_s = ptr >> aw;
    return (upper_s == 16'h0000);
  endfunction

endpackage

// File: rtl/iic_slave_regfile.sv
// Single-port byte RAM: synchronous write, registered read, and a full clear
// sweep to RST_VAL after reset release (clr_busy high while it runs).
module iic_slave_regfile import iic_slave_pkg::*; #(
  parameter int         ADDR_W  = 11,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] clr_addr_r;
  logic              clr_act_r;
  logic [7:0]        rdata_r;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [7:0]        ram_wdata_s;

  // The sweep owns the write port until every location has been cleared.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = addr;
    ram_wdata_s = wdata;
    if (clr_act_r) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = clr_addr_r;
      ram_wdata_s = RST_VAL;
    end else begin
      ram_we_s    = en & we;
    end
  end

  // Clear-sweep address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_act_r  <= 1'b1;
      clr_addr_r <= {ADDR_W{1'b0}};
    end else if (clr_act_r) begin
      clr_addr_r <= clr_addr_r + 1'b1;
      clr_act_r  <= (clr_addr_r != {ADDR_W{1'b1}});
    end else begin
      clr_act_r  <= 1'b0;
      clr_addr_r <= clr_addr_r;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_addr_s] <= ram_wdata_s;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 8'h00;
    end else if (!clr_act_r && en && !we) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata    = rdata_r;
  assign clr_busy = clr_act_r;

endmodule

// File: rtl/iic_slave_reg16.sv
// I2C target with a 16-bit pointer into an 8-bit register file.
// Optional write-event log ports are enabled by defining IIC_SLAVE_WR_LOG_EN.
module iic_slave_reg16 import iic_slave_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         ADDR_W   = 11,
  parameter int         FILT_LEN = 3,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        busy,
  output logic [15:0] wr_cnt
`ifdef IIC_SLAVE_WR_LOG_EN
  ,
  output logic        wr_evt_vld,
  output logic [15:0] wr_evt_addr,
  output logic [7:0]  wr_evt_data
`endif
);

  logic                scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
  logic [FILT_LEN-1:0] scl_hist_r, sda_hist_r;
  logic                scl_filt_r, sda_filt_r, scl_prev_r, sda_prev_r;
  logic                scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t              state_r, state_nxt_s;
  logic [BCNT_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
  logic                full_r, full_nxt_s;
  logic [7:0]          shift_r, shift_nxt_s;
  logic [7:0]          hi_r, hi_nxt_s;
  logic [15:0]         ptr_r, ptr_nxt_s;
  logic [6:0]          tx_r, tx_nxt_s;
  logic                mack_r, mack_nxt_s;
  logic                oe_r, oe_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                rd_oor_r, rd_oor_nxt_s;
  logic [15:0]         wr_cnt_r;

  logic                mem_en_s, mem_we_s, wr_inc_s, clr_busy_s;
  logic [7:0]          rdata_s, rd_byte_s;
`ifdef IIC_SLAVE_WR_LOG_EN
  logic                log_vld_s;
`endif

  // Synchronize and glitch-filter SCL/SDA, keep previous filtered levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      scl_hist_r <= {FILT_LEN{1'b1}};
      sda_hist_r <= {FILT_LEN{1'b1}};
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_meta_r <= scl_i;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= sda_i;
      sda_sync_r <= sda_meta_r;
      scl_hist_r <= {scl_hist_r[FILT_LEN-2:0], scl_sync_r};
      sda_hist_r <= {sda_hist_r[FILT_LEN-2:0], sda_sync_r};
      if (&scl_hist_r)       scl_filt_r <= 1'b1;
      else if (~|scl_hist_r) scl_filt_r <= 1'b0;
      else                   scl_filt_r <= scl_filt_r;
      if (&sda_hist_r)       sda_filt_r <= 1'b1;
      else if (~|sda_hist_r) sda_filt_r <= 1'b0;
      else                   sda_filt_r <= sda_filt_r;
      scl_prev_r <= scl_filt_r;
      sda_prev_r <= sda_filt_r;
    end
  end

  assign scl_rise_s = scl_filt_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_filt_r & scl_prev_r;
  assign start_s    = scl_filt_r & scl_prev_r & sda_prev_r & ~sda_filt_r;
  assign stop_s     = scl_filt_r & scl_prev_r & ~sda_prev_r & sda_filt_r;
  assign rd_byte_s  = rd_oor_r ? RD_OOR_VAL : rdata_s;

  iic_slave_regfile #(
    .ADDR_W  (ADDR_W),
    .RST_VAL (RST_VAL)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mem_en_s),
    .we       (mem_we_s),
    .addr     (ptr_r[ADDR_W-1:0]),
    .wdata    (shift_r),
    .rdata    (rdata_s),
    .clr_busy (clr_busy_s)
  );

  // Next-state and datapath decode; SDA drive only changes on an SCL fall.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    full_nxt_s    = full_r;
    shift_nxt_s   = shift_r;
    hi_nxt_s      = hi_r;
    ptr_nxt_s     = ptr_r;
    tx_nxt_s      = tx_r;
    mack_nxt_s    = mack_r;
    oe_nxt_s      = oe_r;
    busy_nxt_s    = busy_r;
    rd_oor_nxt_s  = rd_oor_r;
    mem_en_s      = 1'b0;
    mem_we_s      = 1'b0;
    wr_inc_s      = 1'b0;
`ifdef IIC_SLAVE_WR_LOG_EN
    log_vld_s     = 1'b0;
`endif
    if (clr_busy_s) begin
      state_nxt_s = ST_IDLE;
      oe_nxt_s    = 1'b0;
      busy_nxt_s  = 1'b0;
    end else if (start_s) begin
      state_nxt_s   = ST_DEV;
      bit_cnt_nxt_s = 3'd0;
      full_nxt_s    = 1'b0;
      oe_nxt_s      = 1'b0;
    end else if (stop_s) begin
      state_nxt_s   = ST_IDLE;
      bit_cnt_nxt_s = 3'd0;
      full_nxt_s    = 1'b0;
      oe_nxt_s      = 1'b0;
      busy_nxt_s    = 1'b0;
    end else if (scl_rise_s) begin
      case (state_r)
        ST_DEV, ST_RA_HI, ST_RA_LO, ST_WDAT: begin
          shift_nxt_s   = {shift_r[6:0], sda_filt_r};
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          full_nxt_s    = (bit_cnt_r == 3'd7);
        end
        ST_RDAT: begin
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            full_nxt_s = 1'b1;
            ptr_nxt_s  = ptr_r + 16'd1;
          end else begin
            full_nxt_s = 1'b0;
          end
        end
        ST_MACK: mack_nxt_s = sda_filt_r;
        default: begin end
      endcase
    end else if (scl_fall_s) begin
      case (state_r)
        ST_DEV: begin
          if (full_r) begin
            full_nxt_s = 1'b0;
            if (shift_r[7:1] == DEV_ADDR) begin
              state_nxt_s = ST_DEV_ACK;
              oe_nxt_s    = 1'b1;
              busy_nxt_s  = 1'b1;
              // Prefetch now so the first read bit is ready after the ACK clock.
              if (shift_r[RW_BIT] == RW_READ) begin
                mem_en_s     = 1'b1;
                rd_oor_nxt_s = ~addr_in_range(ptr_r, ADDR_W);
              end else begin
                mem_en_s     = 1'b0;
              end
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_DEV;
          end
        end
        ST_DEV_ACK: begin
          bit_cnt_nxt_s = 3'd0;
          full_nxt_s    = 1'b0;
          if (shift_r[RW_BIT] == RW_READ) begin
            state_nxt_s = ST_RDAT;
            tx_nxt_s    = rd_byte_s[6:0];
            oe_nxt_s    = ~rd_byte_s[7];
          end else begin
            state_nxt_s = ST_RA_HI;
            oe_nxt_s    = 1'b0;
          end
        end
        ST_RA_HI: begin
          if (full_r) begin
            state_nxt_s = ST_ACK_HI;
            hi_nxt_s    = shift_r;
            full_nxt_s  = 1'b0;
            oe_nxt_s    = 1'b1;
          end else begin
            state_nxt_s = ST_RA_HI;
          end
        end
        ST_ACK_HI: begin
          state_nxt_s = ST_RA_LO;
          oe_nxt_s    = 1'b0;
        end
        ST_RA_LO: begin
          if (full_r) begin
            state_nxt_s = ST_ACK_LO;
            ptr_nxt_s   = {hi_r, shift_r};
            full_nxt_s  = 1'b0;
            oe_nxt_s    = 1'b1;
          end else begin
            state_nxt_s = ST_RA_LO;
          end
        end
        ST_ACK_LO, ST_ACK_W: begin
          state_nxt_s = ST_WDAT;
          oe_nxt_s    = 1'b0;
        end
        ST_WDAT: begin
          if (full_r) begin
            state_nxt_s = ST_ACK_W;
            full_nxt_s  = 1'b0;
            oe_nxt_s    = 1'b1;
            ptr_nxt_s   = ptr_r + 16'd1;
`ifdef IIC_SLAVE_WR_LOG_EN
            log_vld_s   = 1'b1;
`endif
            if (addr_in_range(ptr_r, ADDR_W)) begin
              mem_en_s = 1'b1;
              mem_we_s = 1'b1;
              wr_inc_s = 1'b1;
            end else begin
              wr_inc_s = 1'b0;
            end
          end else begin
            state_nxt_s = ST_WDAT;
          end
        end
        ST_RDAT: begin
          if (full_r) begin
            state_nxt_s  = ST_MACK;
            full_nxt_s   = 1'b0;
            oe_nxt_s     = 1'b0;
            mem_en_s     = 1'b1;
            rd_oor_nxt_s = ~addr_in_range(ptr_r, ADDR_W);
          end else begin
            tx_nxt_s = {tx_r[5:0], 1'b1};
            oe_nxt_s = ~tx_r[6];
          end
        end
        ST_MACK: begin
          bit_cnt_nxt_s = 3'd0;
          if (mack_r == 1'b0) begin
            state_nxt_s = ST_RDAT;
            tx_nxt_s    = rd_byte_s[6:0];
            oe_nxt_s    = ~rd_byte_s[7];
          end else begin
            state_nxt_s = ST_IDLE;
            oe_nxt_s    = 1'b0;
          end
        end
        default: begin end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state and transfer datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      full_r    <= 1'b0;
      shift_r   <= 8'h00;
      hi_r      <= 8'h00;
      ptr_r     <= 16'h0000;
      tx_r      <= 7'h7F;
      mack_r    <= 1'b1;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
      rd_oor_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      full_r    <= full_nxt_s;
      shift_r   <= shift_nxt_s;
      hi_r      <= hi_nxt_s;
      ptr_r     <= ptr_nxt_s;
      tx_r      <= tx_nxt_s;
      mack_r    <= mack_nxt_s;
      oe_r      <= oe_nxt_s;
      busy_r    <= busy_nxt_s;
      rd_oor_r  <= rd_oor_nxt_s;
    end
  end

  // Saturating count of stored data bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r <= 16'h0000;
    end else if (wr_inc_s && (wr_cnt_r != 16'hFFFF)) begin
      wr_cnt_r <= wr_cnt_r + 16'd1;
    end else begin
      wr_cnt_r <= wr_cnt_r;
    end
  end

`ifdef IIC_SLAVE_WR_LOG_EN
  // One-cycle record of every data byte seen in WDAT, stored or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_evt_vld  <= 1'b0;
      wr_evt_addr <= 16'h0000;
      wr_evt_data <= 8'h00;
    end else begin
      wr_evt_vld <= log_vld_s;
      if (log_vld_s) begin
        wr_evt_addr <= ptr_r;
        wr_evt_data <= shift_r;
      end else begin
        wr_evt_addr <= wr_evt_addr;
        wr_evt_data <= wr_evt_data;
      end
    end
  end
`endif

  assign sda_oe = oe_r;
  assign busy   = busy_r;
  assign wr_cnt = wr_cnt_r;

endmodule

// File: tb/tb_iic_slave_reg16.sv
// Directed I2C master with a scoreboard queue drained by a monitor at each
// master sampling point.
module tb_iic_slave_reg16;

  localparam int Q = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, busy;
  logic [15:0] wr_cnt;
`ifdef IIC_SLAVE_WR_LOG_EN
  logic        wr_evt_vld;
  logic [15:0] wr_evt_addr;
  logic [7:0]  wr_evt_data;
`endif

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  iic_slave_reg16 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_i  (scl),
    .sda_i  (sda_bus),
    .sda_oe (sda_oe),
    .busy   (busy),
    .wr_cnt (wr_cnt)
`ifdef IIC_SLAVE_WR_LOG_EN
    ,
    .wr_evt_vld  (wr_evt_vld),
    .wr_evt_addr (wr_evt_addr),
    .wr_evt_data (wr_evt_data)
`endif
  );

  typedef enum {K_SDA, K_OE, K_BUSY, K_WRCNT, K_OESEEN, K_BUSYSEEN} kind_t;
  typedef struct {
    kind_t       kind;
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event obs_ev;
  int   n_vec = 0;
  int   n_bad = 0;

  logic seen_clr = 1'b1;
  logic oe_seen, busy_seen;

  always @(posedge clk) begin
    if (seen_clr) begin
      oe_seen   <= 1'b0;
      busy_seen <= 1'b0;
    end else begin
      if (sda_oe) oe_seen <= 1'b1;
      if (busy)   busy_seen <= 1'b1;
    end
  end

  // Monitor: compare every queued expectation against the DUT outputs now.
  initial forever begin
    @(obs_ev);
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_SDA:      act = {15'd0, sda_bus};
        K_OE:       act = {15'd0, sda_oe};
        K_BUSY:     act = {15'd0, busy};
        K_WRCNT:    act = wr_cnt;
        K_OESEEN:   act = {15'd0, oe_seen};
        default:    act = {15'd0, busy_seen};
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic exp_push(input kind_t k, input string nm, input logic [15:0] v);
    exp_t e;
    e.kind = k;
    e.name = nm;
    e.exp  = v;
    sb_q.push_back(e);
    -> obs_ev;
  endtask

  task automatic i2c_start();
    #Q sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic bit_out(input logic b);
    #Q sda_m = b;
    #Q scl = 1'b1;
    #Q;
    #Q scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic ack, input string nm);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    #Q sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q exp_push(K_SDA, nm, ack ? 16'h0000 : 16'h0001);
    #Q scl = 1'b0;
  endtask

  task automatic rd_byte(input logic [7:0] d, input logic nack, input string nm);
    for (int i = 7; i >= 0; i--) begin
      #Q sda_m = 1'b1;
      #Q scl = 1'b1;
      #Q exp_push(K_SDA, nm, {15'd0, d[i]});
      #Q scl = 1'b0;
    end
    bit_out(nack);
  endtask

  task automatic set_ptr(input logic [15:0] p, input string nm);
    i2c_start();
    wr_byte(8'h90, 1'b1, nm);
    wr_byte(p[15:8], 1'b1, nm);
    wr_byte(p[7:0], 1'b1, nm);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    exp_push(K_OE, "rst_oe", 16'h0000);
    exp_push(K_BUSY, "rst_busy", 16'h0000);
    exp_push(K_WRCNT, "rst_wrcnt", 16'h0000);
    rst_n = 1'b1;
    repeat (2100) @(negedge clk);

    // single write 0x0322 <= 0x30
    set_ptr(16'h0322, "t1_ack");
    wr_byte(8'h30, 1'b1, "t1_data_ack");
    exp_push(K_BUSY, "t1_busy", 16'h0001);
    i2c_stop();
    exp_push(K_BUSY, "t1_busy_stop", 16'h0000);
    exp_push(K_WRCNT, "t1_wrcnt", 16'h0001);

    // burst write 0x040d..0x040f and read it back
    set_ptr(16'h040d, "t2_ack");
    wr_byte(8'h1e, 1'b1, "t2_d0_ack");
    wr_byte(8'h1e, 1'b1, "t2_d1_ack");
    wr_byte(8'h00, 1'b1, "t2_d2_ack");
    i2c_stop();
    exp_push(K_WRCNT, "t2_wrcnt", 16'h0004);
    set_ptr(16'h040d, "t2_rp_ack");
    i2c_start();
    wr_byte(8'h91, 1'b1, "t2_rdev_ack");
    rd_byte(8'h1e, 1'b0, "t2_rd0");
    rd_byte(8'h1e, 1'b0, "t2_rd1");
    rd_byte(8'h00, 1'b1, "t2_rd2");
    i2c_stop();

    // read-back through repeated START
    set_ptr(16'h0322, "t3_ack");
    i2c_start();
    wr_byte(8'h91, 1'b1, "t3_rdev_ack");
    rd_byte(8'h30, 1'b0, "t3_rd0");
    rd_byte(8'h00, 1'b1, "t3_rd1");
    exp_push(K_OE, "t3_oe_after_nack", 16'h0000);
    exp_push(K_BUSY, "t3_busy", 16'h0001);
    i2c_stop();
    exp_push(K_WRCNT, "t3_wrcnt", 16'h0004);

    // foreign address: no ACK anywhere, busy never rises
    seen_clr = 1'b0;
    i2c_start();
    wr_byte(8'h80, 1'b0, "t4_dev_nack");
    wr_byte(8'h03, 1'b0, "t4_b1_nack");
    wr_byte(8'h22, 1'b0, "t4_b2_nack");
    wr_byte(8'h55, 1'b0, "t4_b3_nack");
    i2c_stop();
    exp_push(K_OESEEN, "t4_oe_seen", 16'h0000);
    exp_push(K_BUSYSEEN, "t4_busy_seen", 16'h0000);
    seen_clr = 1'b1;

    // out-of-range write is ACKed but dropped, read returns 0xFF
    set_ptr(16'h0800, "t5_ack");
    wr_byte(8'ha5, 1'b1, "t5_data_ack");
    i2c_stop();
    exp_push(K_WRCNT, "t5_wrcnt", 16'h0004);
    set_ptr(16'h0800, "t5_rp_ack");
    i2c_start();
    wr_byte(8'h91, 1'b1, "t5_rdev_ack");
    rd_byte(8'hff, 1'b1, "t5_rd_oor");
    i2c_stop();

    // asynchronous reset while the data byte is being ACKed
    set_ptr(16'h0020, "t6_ack");
    for (int i = 7; i >= 0; i--) bit_out(i[0]);
    #Q sda_m = 1'b1;
    exp_push(K_OE, "t6_ack_oe", 16'h0001);
    rst_n = 1'b0;
    #2 exp_push(K_OE, "t6_rst_oe", 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scl = 1'b1;
    i2c_start();
    wr_byte(8'h90, 1'b0, "t6_sweep_nack");
    i2c_stop();
    repeat (2100) @(negedge clk);
    exp_push(K_WRCNT, "t6_wrcnt_rst", 16'h0000);
    exp_push(K_BUSY, "t6_busy_rst", 16'h0000);
    set_ptr(16'h040d, "t6_rp_ack");
    i2c_start();
    wr_byte(8'h91, 1'b1, "t6_rdev_ack");
    rd_byte(8'h00, 1'b1, "t6_rd_cleared");
    i2c_stop();
    set_ptr(16'h0010, "t6_w_ack");
    wr_byte(8'hf1, 1'b1, "t6_data_ack");
    i2c_stop();
    exp_push(K_WRCNT, "t6_wrcnt", 16'h0001);
    set_ptr(16'h0010, "t6_rp2_ack");
    i2c_start();
    wr_byte(8'h91, 1'b1, "t6_rdev2_ack");
    rd_byte(8'hf1, 1'b1, "t6_rd_f1");
    i2c_stop();

    #Q;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
